// File: rtl/mean_stream_pkg.sv
// Shared types and width helpers for the streaming mean block.
package mean_stream_pkg;

  typedef enum logic {
    MODE_SLIDE = 1'b0,
    MODE_BLOCK = 1'b1
  } mode_e;

  function automatic int sum_width(input int b, input int n);
    return b + $clog2(n);
  endfunction

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mean_stream_chan.sv
// One channel: circular history, running sum and constant divider.
// Rounding is selected by MEAN_STREAM_ROUND_EN (round half up); truncates otherwise.
module mean_stream_chan
  import mean_stream_pkg::*;
#(
  parameter int N = 5,
  parameter int B = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_acc,
  input  logic                    i_sub_en,
  input  logic                    i_sum_clr,
  input  logic                    i_load,
  input  logic [ptr_width(N)-1:0] i_wr_ptr,
  input  logic [B-1:0]            i_data,
  output logic [B-1:0]            o_mean
);

  localparam int B_SUM = sum_width(B, N);

  logic [B-1:0]     r_hist [N];
  logic [B_SUM-1:0] r_sum;
  logic [B_SUM-1:0] w_old;
  logic [B_SUM-1:0] w_sum_next;
  logic [B-1:0]     w_mean;

  // Oldest sample only leaves the sum once the window is full.
  assign w_old      = i_sub_en ? B_SUM'(r_hist[i_wr_ptr]) : '0;
  assign w_sum_next = r_sum - w_old + B_SUM'(i_data);

`ifdef MEAN_STREAM_ROUND_EN
  logic [B_SUM:0] w_sum_rnd;
  assign w_sum_rnd = {1'b0, w_sum_next} + (B_SUM+1)'(N / 2);
  assign w_mean    = B'(w_sum_rnd / (B_SUM+1)'(N));
`else
  assign w_mean    = B'(w_sum_next / B_SUM'(N));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_hist[i] <= '0;
      r_sum  <= '0;
      o_mean <= '0;
    end else if (i_clr) begin
      r_sum  <= '0;
      o_mean <= '0;
    end else begin
      if (i_acc) begin
        r_hist[i_wr_ptr] <= i_data;
        r_sum            <= i_sum_clr ? '0 : w_sum_next;
      end
      if (i_load) o_mean <= w_mean;
    end
  end

endmodule

// File: rtl/mean_stream.sv
// Streaming per-channel mean over a sliding (MODE=0) or block (MODE=1) window of N beats.
// Optional MEAN_STREAM_ROUND_EN selects round-half-up division in each channel.
module mean_stream
  import mean_stream_pkg::*;
#(
  parameter int N    = 5,
  parameter int B    = 10,
  parameter int C    = 2,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_dval,
  output logic         i_ready,
  input  logic [B-1:0] i_data [C],
  output logic         o_dval,
  input  logic         o_ready,
  output logic [B-1:0] o_data [C],
  output logic         o_full
);

  localparam int PW = ptr_width(N);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
  localparam bit IS_BLOCK = (MODE == int'(MODE_BLOCK));

  logic          r_o_dval;
  logic [PW-1:0] r_wr_ptr;
  logic [FW-1:0] r_fill;
  logic          w_acc;
  logic          w_full;
  logic [FW-1:0] w_fill_inc;
  logic          w_load;
  logic          w_blk_last;

  assign i_ready    = !r_o_dval || o_ready;
  assign w_acc      = i_dval && i_ready;
  assign w_full     = (r_fill == FILL_MAX);
  assign w_fill_inc = w_full ? r_fill : r_fill + 1'b1;
  assign w_load     = w_acc && (w_fill_inc == FILL_MAX);
  // In block mode fill doubles as the block counter and never reaches N.
  assign w_blk_last = IS_BLOCK && w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_dval <= 1'b0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (i_clr) begin
      r_o_dval <= 1'b0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_acc) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        r_fill   <= w_blk_last ? '0 : w_fill_inc;
      end
      if (w_load)       r_o_dval <= 1'b1;
      else if (o_ready) r_o_dval <= 1'b0;
    end
  end

  assign o_dval = r_o_dval;
  assign o_full = w_full;

  for (genvar g = 0; g < C; g++) begin : g_chan
    mean_stream_chan #(
      .N(N),
      .B(B)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (i_clr),
      .i_acc    (w_acc),
      .i_sub_en (w_full),
      .i_sum_clr(w_blk_last),
      .i_load   (w_load),
      .i_wr_ptr (r_wr_ptr),
      .i_data   (i_data[g]),
      .o_mean   (o_data[g])
    );
  end

endmodule

// File: tb/tb_mean_stream.sv
// Self-checking bench: four mean_stream configurations share one randomized stream
// and are compared each cycle against a queue-based window model.
module tb_mean_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic dval = 1'b0;
  logic ordy = 1'b0;
  logic [9:0] d10 [2];
  logic [7:0] d8 [2];
  logic [7:0] od0 [2];
  logic [7:0] od1 [2];
  logic [9:0] od2 [2];
  logic [9:0] od3 [2];
  logic rdy [4];
  logic ov [4];
  logic fl [4];

  int n_chk = 0;
  int n_err = 0;

  // instance configuration: N, MODE, B
  int m_n    [4] = '{4, 4, 5, 3};
  int m_mode [4] = '{0, 1, 0, 1};
  int m_b    [4] = '{8, 8, 10, 10};

  bit m_oval [4];
  int m_odat [8];
  int q      [8][$];
  int lg     [8][$];

`ifdef MEAN_STREAM_ROUND_EN
  localparam int BLK0 = 3;
  localparam int BLK1 = 7;
`else
  localparam int BLK0 = 2;
  localparam int BLK1 = 6;
`endif

  always #5 clk = ~clk;

  mean_stream #(.N(4), .B(8), .C(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_dval(dval), .i_ready(rdy[0]), .i_data(d8),
    .o_dval(ov[0]), .o_ready(ordy), .o_data(od0), .o_full(fl[0]));
  mean_stream #(.N(4), .B(8), .C(2), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_dval(dval), .i_ready(rdy[1]), .i_data(d8),
    .o_dval(ov[1]), .o_ready(ordy), .o_data(od1), .o_full(fl[1]));
  mean_stream #(.N(5), .B(10), .C(2), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_dval(dval), .i_ready(rdy[2]), .i_data(d10),
    .o_dval(ov[2]), .o_ready(ordy), .o_data(od2), .o_full(fl[2]));
  mean_stream #(.N(3), .B(10), .C(2), .MODE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_dval(dval), .i_ready(rdy[3]), .i_data(d10),
    .o_dval(ov[3]), .o_ready(ordy), .o_data(od3), .o_full(fl[3]));

  function automatic int get_od(int k, int c);
    case (k)
      0:       return int'(od0[c]);
      1:       return int'(od1[c]);
      2:       return int'(od2[c]);
      default: return int'(od3[c]);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int mean_of(int k, int c);
    int s = 0;
    foreach (q[k*2+c][i]) s += q[k*2+c][i];
`ifdef MEAN_STREAM_ROUND_EN
    return (s + m_n[k] / 2) / m_n[k];
`else
    return s / m_n[k];
`endif
  endfunction

  task automatic model_clear(int k);
    m_oval[k] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_odat[k*2+c] = 0;
      q[k*2+c].delete();
    end
  endtask

  task automatic model_step(int k);
    bit r;
    bit acc;
    r   = !m_oval[k] || ordy;
    acc = dval && r;
    if (clr) begin
      model_clear(k);
      return;
    end
    if (m_oval[k] && ordy) m_oval[k] = 1'b0;
    if (acc) begin
      for (int c = 0; c < 2; c++) begin
        q[k*2+c].push_back(int'(d10[c]) & ((1 << m_b[k]) - 1));
        if (q[k*2+c].size() > m_n[k]) void'(q[k*2+c].pop_front());
      end
      if (q[k*2].size() == m_n[k]) begin
        for (int c = 0; c < 2; c++) m_odat[k*2+c] = mean_of(k, c);
        m_oval[k] = 1'b1;
        if (m_mode[k] == 1) for (int c = 0; c < 2; c++) q[k*2+c].delete();
      end
    end
  endtask

  always @(posedge clk) if (rst_n) for (int k = 0; k < 4; k++) model_step(k);
  always @(negedge rst_n) for (int k = 0; k < 4; k++) model_clear(k);

  // ---------------- per-cycle compare and output log ----------------
  always begin
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d.i_ready", k), int'(rdy[k]), int'(!m_oval[k] || ordy));
      chk($sformatf("u%0d.o_dval", k), int'(ov[k]), int'(m_oval[k]));
      chk($sformatf("u%0d.o_full", k), int'(fl[k]),
          (m_mode[k] == 0 && q[k*2].size() == m_n[k]) ? 1 : 0);
      if (m_oval[k])
        for (int c = 0; c < 2; c++)
          chk($sformatf("u%0d.o_data[%0d]", k, c), get_od(k, c), m_odat[k*2+c]);
    end
    #3;
    if (rst_n)
      for (int k = 0; k < 4; k++)
        if (ov[k] && ordy)
          for (int c = 0; c < 2; c++) lg[k*2+c].push_back(get_od(k, c));
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit v, int a, int b, bit r, bit c);
    dval   = v;
    d10[0] = 10'(a);
    d10[1] = 10'(b);
    d8[0]  = 8'(a);
    d8[1]  = 8'(b);
    ordy   = r;
    clr    = c;
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 8; i++) lg[i].delete();
  endtask

  task automatic run_a(string tag);
    clear_logs();
    drive(1, 10, 255, 1, 0);
    drive(1, 20, 255, 1, 0);
    drive(1, 30, 255, 1, 0);
    chk({tag, ".no_out_after_3"}, int'(ov[0]), 0);
    chk({tag, ".full_after_3"}, int'(fl[0]), 0);
    drive(1, 40, 255, 1, 0);
    chk({tag, ".full_after_4"}, int'(fl[0]), 1);
    chk({tag, ".dval_after_4"}, int'(ov[0]), 1);
    drive(1, 50, 255, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk({tag, ".out_count"}, lg[0].size(), 2);
    chk({tag, ".ch0_first"}, lg[0][0], 25);
    chk({tag, ".ch0_second"}, lg[0][1], 35);
    chk({tag, ".ch1_first"}, lg[1][0], 255);
    chk({tag, ".ch1_second"}, lg[1][1], 255);
  endtask

  initial begin
    d10[0] = '0; d10[1] = '0; d8[0] = '0; d8[1] = '0;
    @(negedge clk);
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst.u%0d.o_dval", k), int'(ov[k]), 0);
      chk($sformatf("rst.u%0d.o_full", k), int'(fl[k]), 0);
      chk($sformatf("rst.u%0d.o_data0", k), get_od(k, 0), 0);
    end
    rst_n = 1'b1;

    run_a("slide");

    drive(0, 0, 0, 1, 1);
    clear_logs();
    for (int i = 1; i <= 8; i++) drive(1, i, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("block.out_count", lg[2].size(), 2);
    chk("block.first", lg[2][0], BLK0);
    chk("block.second", lg[2][1], BLK1);

    drive(0, 0, 0, 1, 1);
    clear_logs();
    for (int i = 0; i < 5; i++) drive(1, 1023, 1023, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("max.out_count", lg[4].size(), 1);
    chk("max.ch0", lg[4][0], 1023);
    chk("max.ch1", lg[5][0], 1023);

    drive(0, 0, 0, 1, 1);
    clear_logs();
    drive(1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    drive(1, 2, 2, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("n3.out_count", lg[6].size(), 1);
    chk("n3.mean", lg[6][0], 1);

    drive(0, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) drive(1, 4 * i, 4 * i, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 20, 20, 0, 0);
      chk("stall.i_ready", int'(rdy[0]), 0);
      chk("stall.o_data", int'(od0[0]), 10);
    end
    drive(1, 20, 20, 1, 0);
    chk("stall.resume_dval", int'(ov[0]), 1);
    chk("stall.resume_data", int'(od0[0]), 14);

    drive(0, 0, 0, 1, 1);
    for (int i = 1; i <= 5; i++) drive(1, 4 * i, 4 * i, 1, 0);
    drive(1, 24, 24, 1, 1);
    chk("clr.o_dval", int'(ov[0]), 0);
    chk("clr.o_full", int'(fl[0]), 0);
    for (int i = 1; i <= 3; i++) drive(1, 4 * i, 4 * i, 1, 0);
    chk("clr.no_early_out", int'(ov[0]), 0);
    drive(1, 16, 16, 1, 0);
    chk("clr.refill_dval", int'(ov[0]), 1);
    chk("clr.refill_data", int'(od0[0]), 10);

    drive(0, 0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) drive(1, 100 + i, 7 * i, 1, 0);
    #1;
    rst_n = 1'b0;
    dval  = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst.u%0d.o_dval", k), int'(ov[k]), 0);
      chk($sformatf("midrst.u%0d.o_full", k), int'(fl[k]), 0);
      chk($sformatf("midrst.u%0d.o_data0", k), get_od(k, 0), 0);
      chk($sformatf("midrst.u%0d.o_data1", k), get_od(k, 1), 0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    run_a("post_rst");

    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) != 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            ($urandom % 10) < 7, ($urandom % 100) == 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
